// File: rtl/noc_pkg.sv
// noc_pkg: shared widths, tuser field layout and mesh helpers for the AXI-S NoC
package noc_pkg;
    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int IDW = 2;
    localparam int DESTW = 4;
    localparam int MESH_COLS = 4;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W = 9;
    localparam int TYPE_LSB = 9;
    localparam int TYPE_W = 2;
    localparam int RFEN_LSB = 11;
    localparam int RFEN_W = 64;
    localparam logic [TYPE_W-1:0] TYPE_INST = 2'b00;
    localparam logic [TYPE_W-1:0] TYPE_INPUT = 2'b10;
    localparam logic [TYPE_W-1:0] TYPE_WEIGHT = 2'b11;

    function automatic int node_r(input int node);
        return node / MESH_COLS;
    endfunction

    function automatic int node_c(input int node);
        return node % MESH_COLS;
    endfunction
endpackage

// File: rtl/axis_dispatcher_if.sv
// axis_dispatcher_if: host write port plus AXI-S transmit stream of the dispatcher
interface axis_dispatcher_if;
    import noc_pkg::*;
    logic data_fifo_wen;
    logic [DATAW-1:0] data_fifo_wdata;
    logic data_last;
    logic data_fifo_rdy;
    logic axis_tx_tvalid;
    logic axis_tx_tready;
    logic [DATAW+USERW-1:0] axis_tx_tdata;
    logic axis_tx_tlast;
    logic [IDW-1:0] axis_tx_tid;
    logic [DESTW-1:0] axis_tx_tdest;

    modport master (
        input data_fifo_wen, data_fifo_wdata, data_last, axis_tx_tready,
        output data_fifo_rdy, axis_tx_tvalid, axis_tx_tdata, axis_tx_tlast, axis_tx_tid, axis_tx_tdest
    );

    modport slave (
        output data_fifo_wen, data_fifo_wdata, data_last, axis_tx_tready,
        input data_fifo_rdy, axis_tx_tvalid, axis_tx_tdata, axis_tx_tlast, axis_tx_tid, axis_tx_tdest
    );
endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FIFO with occupancy count and first-word-fall-through head
module axis_sync_fifo #(
    parameter int W = 8,
    parameter int D = 8,
    parameter int CW = $clog2(D + 1)
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [CW-1:0] count,
    output logic empty
);
    localparam int AW = $clog2(D);
    logic [W-1:0] mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic full, push_ok, pop_ok;

    assign full = count == CW'(D);
    assign empty = count == '0;
    assign push_ok = push & !full;
    assign pop_ok = pop & !empty;
    assign dout = mem[rd_ptr];

    // storage array carries no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/axis_dispatcher.sv
// axis_dispatcher: buffers host input vectors and emits them as tagged AXI-S beats to one MVM node
module axis_dispatcher
    import noc_pkg::*;
#(
    parameter int DESTNODE = 0,
    parameter logic [USERW-1:0] USER_TAG = {{RFEN_W{1'b0}}, TYPE_INPUT, {ADDR_W{1'b0}}},
    parameter int FIFO_DEPTH = 8
) (
    input logic clk,
    input logic rst_n,
    axis_dispatcher_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_Q = (CW + 1)'(FIFO_DEPTH);
    logic [CW-1:0] fifo_count;
    logic [CW:0] occupancy;
    logic fifo_empty, push, load, slot_valid;
    logic [DATAW:0] head, slot;

    // the output slot counts toward capacity so at most FIFO_DEPTH vectors are held in total
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, slot_valid};
    assign bus.data_fifo_rdy = occupancy < DEPTH_Q;
    assign push = bus.data_fifo_wen & bus.data_fifo_rdy;
    assign load = !fifo_empty & (!slot_valid | bus.axis_tx_tready);

    axis_sync_fifo #(.W(DATAW + 1), .D(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(load),
        .din({bus.data_last, bus.data_fifo_wdata}),
        .dout(head),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    // slot occupancy: refill from the FIFO head whenever the slot is empty or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_valid <= 1'b0;
        else if (load) slot_valid <= 1'b1;
        else if (bus.axis_tx_tready) slot_valid <= 1'b0;
    end

    // slot payload; outputs are gated by slot_valid so it needs no reset
    always_ff @(posedge clk) begin
        if (load) slot <= head;
    end

    assign bus.axis_tx_tvalid = slot_valid;
    assign bus.axis_tx_tdata = slot_valid ? {USER_TAG, slot[DATAW-1:0]} : '0;
    assign bus.axis_tx_tlast = slot_valid & slot[DATAW];
    assign bus.axis_tx_tid = '0;
    assign bus.axis_tx_tdest = DESTW'(DESTNODE);
endmodule

// File: tb/tb_axis_dispatcher.sv
// tb_axis_dispatcher: randomized and directed checks of the dispatcher against a queue model
module tb_axis_dispatcher;
    import noc_pkg::*;
    localparam int DEPTH = 8;
    localparam int DEST = 2;
    localparam logic [USERW-1:0] TAG = 75'h400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [DATAW:0] q[$];
    int occ = 0;
    bit just = 1'b0;
    int beats = 0;
    int pushed = 0;

    always #5 clk = ~clk;

    axis_dispatcher_if bus();

    axis_dispatcher #(.DESTNODE(DEST), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [DATAW+USERW-1:0] got, input logic [DATAW+USERW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] rand_vec();
        logic [DATAW-1:0] v;
        for (int i = 0; i < DATAW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // one clock: drive, check visible state against the model, advance the model across the edge
    task automatic cycle(input bit wen, input logic [DATAW-1:0] d, input bit last, input bit rdy_in);
        bit acc, vld;
        bus.data_fifo_wen = wen;
        bus.data_fifo_wdata = d;
        bus.data_last = last;
        bus.axis_tx_tready = rdy_in;
        #1;
        vld = (occ - int'(just)) > 0;
        check("rdy", bus.data_fifo_rdy, occ < DEPTH);
        check("tvalid", bus.axis_tx_tvalid, vld);
        if (vld) begin
            check("tdata", bus.axis_tx_tdata, {TAG, q[0][DATAW-1:0]});
            check("tlast", bus.axis_tx_tlast, q[0][DATAW]);
        end
        acc = wen && occ < DEPTH;
        @(posedge clk);
        if (vld && rdy_in) begin
            void'(q.pop_front());
            occ--;
            beats++;
        end
        if (acc) begin
            q.push_back({last, d});
            occ++;
            pushed++;
        end
        just = acc;
        @(negedge clk);
    endtask

    initial begin
        logic [DATAW-1:0] d;
        int start, guard;
        bus.data_fifo_wen = 1'b0;
        bus.data_fifo_wdata = '0;
        bus.data_last = 1'b0;
        bus.axis_tx_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", bus.axis_tx_tvalid, 0);
        check("rst_rdy", bus.data_fifo_rdy, 1);
        check("rst_tdata", bus.axis_tx_tdata, 0);
        check("rst_tlast", bus.axis_tx_tlast, 0);
        check("tid", bus.axis_tx_tid, 0);
        check("tdest", bus.axis_tx_tdest, DEST);
        rst_n = 1'b1;
        @(negedge clk);

        d = '0;
        d[7:0] = 8'd5;
        d[511:504] = 8'd200;
        cycle(1, d, 1, 1);
        cycle(0, '0, 0, 0);
        check("single_tvalid", bus.axis_tx_tvalid, 1);
        check("single_lane0", bus.axis_tx_tdata[7:0], 5);
        check("single_lane63", bus.axis_tx_tdata[511:504], 200);
        check("single_tag", bus.axis_tx_tdata[586:512], TAG);
        check("single_tdest", bus.axis_tx_tdest, DEST);
        check("single_tid", bus.axis_tx_tid, 0);
        check("single_tlast", bus.axis_tx_tlast, 1);
        repeat (4) cycle(0, '0, 0, 0);
        cycle(0, '0, 0, 1);
        check("bp_after", bus.axis_tx_tvalid, 0);

        for (int i = 1; i <= 9; i++) begin
            d = DATAW'(i);
            cycle(1, d, i == 3 || i == 8, 0);
            if (i == 8) check("full_rdy", bus.data_fifo_rdy, 0);
        end
        beats = 0;
        repeat (12) cycle(0, '0, 0, 1);
        check("full_beats", beats, 8);

        beats = 0;
        for (int i = 0; i < 16; i++) cycle(1, rand_vec(), i == 15, 1);
        repeat (3) cycle(0, '0, 0, 1);
        check("stream_beats", beats, 16);

        for (int i = 0; i < 3; i++) cycle(1, rand_vec(), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tvalid", bus.axis_tx_tvalid, 0);
        check("midrst_rdy", bus.data_fifo_rdy, 1);
        check("midrst_tdata", bus.axis_tx_tdata, 0);
        check("midrst_tlast", bus.axis_tx_tlast, 0);
        q.delete();
        occ = 0;
        just = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) cycle(0, '0, 0, 1);

        start = pushed;
        guard = 0;
        while (pushed - start < 1000 && guard < 20000) begin
            cycle($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            guard++;
        end
        repeat (30) cycle(0, '0, 0, 1);
        check("random_count", pushed - start, 1000);
        check("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
